// File: rtl/xfer_pkg.sv
// xfer_pkg: opcode/state types and static bus-control decode for the A/B transfer sequencer.
package xfer_pkg;

   localparam int SETTLE_W = 4;

   typedef enum logic [2:0] {
      OP_NOP     = 3'd0,
      OP_LOAD_A  = 3'd1,
      OP_LOAD_B  = 3'd2,
      OP_MOV_AB  = 3'd3,
      OP_MOV_BA  = 3'd4,
      OP_STORE_A = 3'd5,
      OP_STORE_B = 3'd6,
      OP_ILL     = 3'd7
   } op_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_WAIT,
      S_EXEC,
      S_DONE
   } state_t;

   // Controls held steady from SETUP through EXEC; the output enables are active-low.
   typedef struct packed {
      logic sel_a;
      logic sel_b;
      logic oea_n;
      logic oeb_n;
   } bus_ctrl_t;

   localparam bus_ctrl_t BUS_IDLE = '{sel_a: 1'b0, sel_b: 1'b0, oea_n: 1'b1, oeb_n: 1'b1};

   // Only one driver is ever enabled per op, so the shared bus cannot see contention.
   function automatic bus_ctrl_t bus_ctrl(input op_t op);
      bus_ctrl_t c;
      c = BUS_IDLE;
      case (op)
         OP_LOAD_A:             c.sel_a = 1'b1;
         OP_LOAD_B:             c.sel_b = 1'b1;
         OP_MOV_AB, OP_STORE_A: c.oea_n = 1'b0;
         OP_MOV_BA, OP_STORE_B: c.oeb_n = 1'b0;
         default:               c = BUS_IDLE;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/xfer_ctrl.sv
// xfer_ctrl: single-command SETUP->EXEC->DONE sequencer driving the A/B datapath strobes.
// Build option: define XFER_STORE_EN to execute STORE_A/STORE_B; otherwise they finish with err.
module xfer_ctrl
   import xfer_pkg::*;
#(
   parameter int ADDR_W     = 5,
   parameter int SETTLE_CYC = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [2:0]        cmd_op,
   input  logic [ADDR_W-1:0] cmd_addr,
   output logic              done,
   output logic              err,
   output logic              SEL_A,
   output logic              SEL_B,
   output logic              LD_A,
   output logic              LD_B,
   output logic              OEA,
   output logic              OEB,
   output logic [ADDR_W-1:0] DataA,
   output logic [ADDR_W-1:0] DataB,
   output logic              FR_W,
   output logic [ADDR_W-1:0] FR_WADDR
);

   localparam logic [SETTLE_W-1:0] SETTLE_LAST =
      (SETTLE_CYC > 0) ? SETTLE_W'(SETTLE_CYC - 1) : '0;

   state_t                state_q;
   op_t                   op_q;
   logic [SETTLE_W-1:0]   cnt_q;
   bus_ctrl_t             bus_q;
   logic [ADDR_W-1:0]     data_a_q;
   logic [ADDR_W-1:0]     data_b_q;
   logic                  ld_a_q;
   logic                  ld_b_q;
   logic                  done_q;
   logic                  err_q;
   logic                  rdy_q;
`ifdef XFER_STORE_EN
   logic                  fr_w_q;
   logic [ADDR_W-1:0]     fr_waddr_q;
   logic                  exec_fr_w;
`endif

   op_t  cmd_op_e;
   logic cmd_runs;
   logic cmd_is_nop;
   logic exec_ld_a;
   logic exec_ld_b;

   always_comb begin
      cmd_op_e   = op_t'(cmd_op);
      cmd_is_nop = (cmd_op_e == OP_NOP);
      case (cmd_op_e)
         OP_LOAD_A, OP_LOAD_B, OP_MOV_AB, OP_MOV_BA: cmd_runs = 1'b1;
`ifdef XFER_STORE_EN
         OP_STORE_A, OP_STORE_B:                     cmd_runs = 1'b1;
`endif
         default:                                    cmd_runs = 1'b0;
      endcase
      exec_ld_a = (op_q == OP_LOAD_A) || (op_q == OP_MOV_BA);
      exec_ld_b = (op_q == OP_LOAD_B) || (op_q == OP_MOV_AB);
`ifdef XFER_STORE_EN
      exec_fr_w = (op_q == OP_STORE_A) || (op_q == OP_STORE_B);
`endif
   end

   // NOTE: all state and registered outputs use non-blocking assignments; the async
   // reset branch forces every output to its idle value without waiting for a clock.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         op_q       <= OP_NOP;
         cnt_q      <= '0;
         bus_q      <= BUS_IDLE;
         data_a_q   <= '0;
         data_b_q   <= '0;
         ld_a_q     <= 1'b0;
         ld_b_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         rdy_q      <= 1'b1;
`ifdef XFER_STORE_EN
         fr_w_q     <= 1'b0;
         fr_waddr_q <= '0;
`endif
      end else begin
         // Strobes and the done/err pulses default low so each lasts exactly one cycle.
         ld_a_q <= 1'b0;
         ld_b_q <= 1'b0;
         done_q <= 1'b0;
         err_q  <= 1'b0;
`ifdef XFER_STORE_EN
         fr_w_q <= 1'b0;
`endif
         case (state_q)
            S_IDLE: begin
               if (cmd_valid) begin
                  op_q  <= cmd_op_e;
                  rdy_q <= 1'b0;
                  if (cmd_runs) begin
                     state_q <= S_SETUP;
                     bus_q   <= bus_ctrl(cmd_op_e);
                     if (cmd_op_e == OP_LOAD_A) data_a_q <= cmd_addr;
                     if (cmd_op_e == OP_LOAD_B) data_b_q <= cmd_addr;
`ifdef XFER_STORE_EN
                     if ((cmd_op_e == OP_STORE_A) || (cmd_op_e == OP_STORE_B))
                        fr_waddr_q <= cmd_addr;
`endif
                  end else begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                     err_q   <= !cmd_is_nop;
                  end
               end
            end
            S_SETUP: begin
               if (SETTLE_CYC == 0) begin
                  state_q <= S_EXEC;
                  ld_a_q  <= exec_ld_a;
                  ld_b_q  <= exec_ld_b;
`ifdef XFER_STORE_EN
                  fr_w_q  <= exec_fr_w;
`endif
               end else begin
                  state_q <= S_WAIT;
                  cnt_q   <= SETTLE_LAST;
               end
            end
            S_WAIT: begin
               if (cnt_q == '0) begin
                  state_q <= S_EXEC;
                  ld_a_q  <= exec_ld_a;
                  ld_b_q  <= exec_ld_b;
`ifdef XFER_STORE_EN
                  fr_w_q  <= exec_fr_w;
`endif
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            S_EXEC: begin
               state_q  <= S_DONE;
               bus_q    <= BUS_IDLE;
               data_a_q <= '0;
               data_b_q <= '0;
               done_q   <= 1'b1;
`ifdef XFER_STORE_EN
               fr_waddr_q <= '0;
`endif
            end
            S_DONE: begin
               state_q <= S_IDLE;
               rdy_q   <= 1'b1;
            end
            default: begin
               state_q <= S_IDLE;
               bus_q   <= BUS_IDLE;
               rdy_q   <= 1'b1;
            end
         endcase
      end
   end

   assign cmd_ready = rdy_q;
   assign done      = done_q;
   assign err       = err_q;
   assign SEL_A     = bus_q.sel_a;
   assign SEL_B     = bus_q.sel_b;
   assign OEA       = bus_q.oea_n;
   assign OEB       = bus_q.oeb_n;
   assign LD_A      = ld_a_q;
   assign LD_B      = ld_b_q;
   assign DataA     = data_a_q;
   assign DataB     = data_b_q;
`ifdef XFER_STORE_EN
   assign FR_W      = fr_w_q;
   assign FR_WADDR  = fr_waddr_q;
`else
   assign FR_W      = 1'b0;
   assign FR_WADDR  = '0;
`endif

endmodule

// File: tb/tb_xfer_ctrl.sv
// tb_xfer_ctrl: directed bench for xfer_ctrl with SETTLE_CYC=0 and 3 plus a small A/B/RF datapath model.
module tb_xfer_ctrl;
   import xfer_pkg::*;

   typedef struct packed {
      logic       rdy, done, err, sel_a, sel_b, ld_a, ld_b, oea, oeb, fr_w;
      logic [4:0] data_a, data_b, waddr;
   } obs_t;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       v0 = 1'b0;
   logic       v3 = 1'b0;
   logic [2:0] op = 3'd0;
   logic [4:0] addr = 5'd0;

   logic       rdy0, done0, err0, sela0, selb0, lda0, ldb0, oea0, oeb0, frw0;
   logic [4:0] da0, db0, wa0;
   logic       rdy3, done3, err3, sela3, selb3, lda3, ldb3, oea3, oeb3, frw3;
   logic [4:0] da3, db3, wa3;

   always #5 clk = ~clk;

   xfer_ctrl #(.ADDR_W(5), .SETTLE_CYC(0)) dut0 (
      .clk(clk), .rst(rst), .cmd_valid(v0), .cmd_ready(rdy0), .cmd_op(op), .cmd_addr(addr),
      .done(done0), .err(err0), .SEL_A(sela0), .SEL_B(selb0), .LD_A(lda0), .LD_B(ldb0),
      .OEA(oea0), .OEB(oeb0), .DataA(da0), .DataB(db0), .FR_W(frw0), .FR_WADDR(wa0)
   );

   xfer_ctrl #(.ADDR_W(5), .SETTLE_CYC(3)) dut3 (
      .clk(clk), .rst(rst), .cmd_valid(v3), .cmd_ready(rdy3), .cmd_op(op), .cmd_addr(addr),
      .done(done3), .err(err3), .SEL_A(sela3), .SEL_B(selb3), .LD_A(lda3), .LD_B(ldb3),
      .OEA(oea3), .OEB(oeb3), .DataA(da3), .DataB(db3), .FR_W(frw3), .FR_WADDR(wa3)
   );

   obs_t s0, s3;
   assign s0 = {rdy0, done0, err0, sela0, selb0, lda0, ldb0, oea0, oeb0, frw0, da0, db0, wa0};
   assign s3 = {rdy3, done3, err3, sela3, selb3, lda3, ldb3, oea3, oeb3, frw3, da3, db3, wa3};

   // Datapath around dut0: register file, A/B registers and the shared bus.
   logic [7:0] rf [32];
   logic [7:0] a_q, b_q, bus;
   assign bus = !oea0 ? a_q : (!oeb0 ? b_q : 8'hxx);

   function automatic logic [7:0] rf_init(input int i);
      case (i)
         0:       return 8'h06;
         1:       return 8'h05;
         3:       return 8'h3C;
         5:       return 8'h55;
         default: return 8'(i);
      endcase
   endfunction

   always @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < 32; i++) rf[i] <= rf_init(i);
      end else begin
         if (lda0) a_q <= sela0 ? rf[da0] : bus;
         if (ldb0) b_q <= selb0 ? rf[db0] : bus;
         if (frw0) rf[wa0] <= bus;
      end
   end

   int viol = 0;
   always @(negedge clk) begin
      if (rst) begin
         if (!oea0 && !oeb0) viol++;
         if (!oea3 && !oeb3) viol++;
         if (int'(lda0) + int'(ldb0) + int'(frw0) > 1) viol++;
         if (int'(lda3) + int'(ldb3) + int'(frw3) > 1) viol++;
      end
   end

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Per-cycle traces; bit i is the value sampled in cycle i+1 after the accept edge.
   logic [11:0] t_rdy, t_done, t_err, t_sela, t_selb, t_lda, t_ldb, t_oea_n, t_oeb_n, t_frw;
   logic [4:0]  c1_da, c1_db, c1_wa;

   task automatic run_cmd(input bit on3, input logic [2:0] o, input logic [4:0] a);
      obs_t s;
      @(negedge clk);
      op = o;
      addr = a;
      if (on3) v3 = 1'b1; else v0 = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 12; i++) begin
         s = on3 ? s3 : s0;
         t_rdy[i]   = s.rdy;
         t_done[i]  = s.done;
         t_err[i]   = s.err;
         t_sela[i]  = s.sel_a;
         t_selb[i]  = s.sel_b;
         t_lda[i]   = s.ld_a;
         t_ldb[i]   = s.ld_b;
         t_oea_n[i] = ~s.oea;
         t_oeb_n[i] = ~s.oeb;
         t_frw[i]   = s.fr_w;
         if (i == 0) begin
            c1_da = s.data_a;
            c1_db = s.data_b;
            c1_wa = s.waddr;
            // Busy: valid stays up with a different op/addr, which must be ignored.
            op   = 3'd7;
            addr = ~a;
         end
         if (i == 1) begin
            v0 = 1'b0;
            v3 = 1'b0;
         end
         @(negedge clk);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   logic [4:0] bb_done, bb_rdy;
   logic       seen_done;

   initial begin
      repeat (3) @(negedge clk);
      check("rst_ready",  rdy0, 1);
      check("rst_done",   {done0, err0}, 0);
      check("rst_oe",     {oea0, oeb0}, 2'b11);
      check("rst_sel_ld", {sela0, selb0, lda0, ldb0, frw0}, 0);
      check("rst_addrs",  {da0, db0, wa0}, 0);
      check("rst_dut3",   {rdy3, oea3, oeb3, done3}, 4'b1110);
      rst = 1'b1;

      run_cmd(0, OP_LOAD_A, 5'd0);
      check("lda_ld_a",  t_lda,  12'h002);
      check("lda_sel_a", t_sela, 12'h003);
      check("lda_done",  t_done, 12'h004);
      check("lda_other", t_ldb | t_frw | t_err, 0);
      check("lda_ready", t_rdy,  12'hFF8);
      check("lda_A",     a_q,    8'h06);

      run_cmd(0, OP_LOAD_B, 5'd1);
      check("ldb_ld_b",  t_ldb,  12'h002);
      check("ldb_sel_b", t_selb, 12'h003);
      check("ldb_dataB", c1_db,  5'd1);
      check("ldb_B",     b_q,    8'h05);

      run_cmd(0, OP_MOV_BA, 5'd9);
      check("mba_oeb",   t_oeb_n, 12'h003);
      check("mba_oea",   t_oea_n, 0);
      check("mba_ld_a",  t_lda,   12'h002);
      check("mba_sel",   t_sela | t_selb, 0);
      check("mba_A",     a_q,     8'h05);

      run_cmd(0, OP_ILL, 5'd2);
      check("ill_done",  t_done, 12'h001);
      check("ill_err",   t_err,  12'h001);
      check("ill_strb",  t_lda | t_ldb | t_frw, 0);
      check("ill_oe",    t_oea_n | t_oeb_n, 0);
      check("ill_ready", t_rdy,  12'hFFE);

      run_cmd(0, OP_NOP, 5'd2);
      check("nop_done",  t_done, 12'h001);
      check("nop_err",   t_err,  0);
      check("nop_strb",  t_lda | t_ldb | t_frw, 0);

      run_cmd(0, OP_STORE_A, 5'd5);
`ifdef XFER_STORE_EN
      check("sta_oea",   t_oea_n, 12'h003);
      check("sta_fr_w",  t_frw,   12'h002);
      check("sta_waddr", c1_wa,   5'd5);
      check("sta_done",  {t_err, t_done}, {12'h000, 12'h004});
      check("sta_rf5",   rf[5],   8'h05);
`else
      check("sta_done",  t_done,  12'h001);
      check("sta_err",   t_err,   12'h001);
      check("sta_fr_w",  t_frw,   0);
      check("sta_waddr", c1_wa,   0);
      check("sta_oe",    t_oea_n | t_oeb_n, 0);
      check("sta_rf5",   rf[5],   8'h55);
`endif

      run_cmd(0, OP_LOAD_A, 5'd3);
      check("lda3_dataA", c1_da, 5'd3);
      check("lda3_A",     a_q,   8'h3C);

      run_cmd(0, OP_MOV_AB, 5'd0);
      check("mab0_ld_b", t_ldb,   12'h002);
      check("mab0_oea",  t_oea_n, 12'h003);
      check("mab0_B",    b_q,     8'h3C);

      run_cmd(1, OP_MOV_AB, 5'd0);
      check("mab3_ld_b",  t_ldb,   12'h010);
      check("mab3_done",  t_done,  12'h020);
      check("mab3_oea",   t_oea_n, 12'h01F);
      check("mab3_oeb",   t_oeb_n, 0);
      check("mab3_ready", t_rdy,   12'hFC0);

      // Back-to-back NOPs with valid held: second accepted in the IDLE cycle right after done.
      @(negedge clk);
      op = OP_NOP;
      v0 = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         bb_done[i] = done0;
         bb_rdy[i]  = rdy0;
         if (i == 2) v0 = 1'b0;
      end
      check("b2b_done",  bb_done, 5'b00101);
      check("b2b_ready", bb_rdy,  5'b11010);

      // Reset asserted during EXEC of a LOAD_A aborts it.
      @(negedge clk);
      op = OP_LOAD_A;
      addr = 5'd4;
      v0 = 1'b1;
      @(negedge clk);
      v0 = 1'b0;
      @(negedge clk);
      check("rx_pre_ld_a", lda0, 1);
      #2 rst = 1'b0;
      #1;
      check("rx_ld_a",  lda0, 0);
      check("rx_oe",    {oea0, oeb0}, 2'b11);
      check("rx_ready", rdy0, 1);
      check("rx_ctrl",  {sela0, da0, done0}, 0);
      @(negedge clk);
      rst = 1'b1;
      seen_done = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         seen_done = seen_done | done0;
      end
      check("rx_no_done", seen_done, 0);
      check("rx_A_kept",  a_q, 8'h3C);

      check("invariants", viol, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
